// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 iterative controllers.
package aes_pkg;

  localparam int AES_BLK_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Round constants indexed by round number; entry 0 is the "no round" value.
  localparam logic [7:0] AES_RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_rcon_lut.sv
// Round number to key-expansion round constant.
module aes_rcon_lut
  import aes_pkg::*;
(
  input  logic [3:0] round,
  output logic [7:0] rcon
);

  // Rounds beyond the last table entry have no constant.
  always_comb begin
    rcon = '0;
    if (round <= 4'(AES_NUM_ROUNDS)) begin
      rcon = AES_RCON[round];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state/key round
// registers and round counter, and steps an external round datapath.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int BLK_W      = AES_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
  output logic [BLK_W-1:0] rd_state,
  output logic [BLK_W-1:0] rd_key,
  output logic [3:0]       rd_round,
  output logic [7:0]       rd_rcon,
  output logic             rd_final,
  input  logic [BLK_W-1:0] rd_state_nxt,
  input  logic [BLK_W-1:0] rd_key_nxt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data
);

  aes_state_e       state;
  aes_state_e       state_nxt;
  logic [BLK_W-1:0] state_reg;
  logic [BLK_W-1:0] key_reg;
  logic [3:0]       round;
  logic             last_round;
  logic             accept;
  logic             step;
  logic             release_blk;

  assign last_round = (round == 4'(NUM_ROUNDS));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus handshake and register-update strobes
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    rd_final    = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    release_blk = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        step     = 1'b1;
        rd_final = last_round;
        if (last_round) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_blk = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round state and round key registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
    end else if (accept) begin
      state_reg <= in_data ^ in_key;
      key_reg   <= in_key;
    end else if (step) begin
      state_reg <= rd_state_nxt;
      key_reg   <= rd_key_nxt;
    end
  end

  // Round counter: holds at the last round through DONE, cleared on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round <= '0;
    end else if (accept) begin
      round <= 4'd1;
    end else if (step && !last_round) begin
      round <= round + 4'd1;
    end else if (release_blk) begin
      round <= '0;
    end
  end

  // Ciphertext register and output valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (step && last_round) begin
      out_data  <= rd_state_nxt;
      out_valid <= 1'b1;
    end else if (release_blk) begin
      out_valid <= 1'b0;
    end
  end

  assign rd_state = state_reg;
  assign rd_key   = key_reg;
  assign rd_round = round;

  aes_rcon_lut u_rcon (
    .round (round),
    .rcon  (rd_rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with a reference AES round datapath.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic [127:0] rd_state;
  logic [127:0] rd_key;
  logic [3:0]   rd_round;
  logic [7:0]   rd_rcon;
  logic         rd_final;
  logic [127:0] rd_state_nxt;
  logic [127:0] rd_key_nxt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] rc_lit [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_round_ctrl #(.NUM_ROUNDS(10), .BLK_W(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_key       (in_key),
    .rd_state     (rd_state),
    .rd_key       (rd_key),
    .rd_round     (rd_round),
    .rd_rcon      (rd_rcon),
    .rd_final     (rd_final),
    .rd_state_nxt (rd_state_nxt),
    .rd_key_nxt   (rd_key_nxt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] v;
    v = 8'h01;
    if (r == 0) return 8'h00;
    for (int i = 1; i < r; i++) v = xt(v);
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit fin);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[rw+4*c] = a[rw + 4*((c+rw)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = t[4*c]; c1 = t[4*c+1]; c2 = t[4*c+2]; c3 = t[4*c+3];
        t[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        t[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        t[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        t[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_expand(k, rcon_of(r));
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // Reference round datapath driven by the controller.
  assign rd_key_nxt   = key_expand(rd_key, rd_rcon);
  assign rd_state_nxt = aes_round(rd_state, rd_key_nxt, rd_final);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- cycle-level model and per-cycle compare ----------------
  // phase 0 = waiting for input, 1..10 = round number, 11 = ciphertext held.
  int           phase;
  logic [127:0] m_out;
  logic [127:0] m_st [11];
  logic [127:0] m_rk [11];

  initial begin : model_compare
    int er;
    phase = 0;
    m_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        m_out = '0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_rd_round", 128'(rd_round), 128'(0));
        chk("rst_rd_final", 128'(rd_final), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
      end else begin
        er = (phase >= 1 && phase <= 10) ? phase : ((phase == 11) ? 10 : 0);
        chk("m_in_ready", 128'(in_ready), 128'(phase == 0));
        chk("m_out_valid", 128'(out_valid), 128'(phase == 11));
        chk("m_rd_round", 128'(rd_round), 128'(er));
        chk("m_rd_rcon", 128'(rd_rcon), 128'(rcon_of(er)));
        chk("m_rd_final", 128'(rd_final), 128'(phase == 10));
        chk("m_out_data", out_data, m_out);
        if (phase >= 1 && phase <= 10) begin
          chk("m_rd_state", rd_state, m_st[phase-1]);
          chk("m_rd_key", rd_key, m_rk[phase-1]);
        end
        if (phase == 0) begin
          if (in_valid) begin
            m_st[0] = in_data ^ in_key;
            m_rk[0] = in_key;
            for (int r = 1; r <= 10; r++) begin
              m_rk[r] = key_expand(m_rk[r-1], rcon_of(r));
              m_st[r] = aes_round(m_st[r-1], m_rk[r], r == 10);
            end
            phase = 1;
          end
        end else if (phase <= 10) begin
          if (phase == 10) m_out = m_st[10];
          phase++;
        end else if (out_ready) begin
          phase = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold,
                           input bit noise, input bit pin);
    int n;
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      if (pin && n < 10) begin
        chk("pin_round", 128'(rd_round), 128'(n + 1));
        chk("pin_rcon", 128'(rd_rcon), 128'(rc_lit[n]));
        chk("pin_final", 128'(rd_final), 128'(n == 9));
      end
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(n), 128'(10));
    chk("ciphertext", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_out_data", out_data, exp);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", 128'(in_ready), 128'(1));
    chk("release_out_valid", 128'(out_valid), 128'(0));
  endtask

  task automatic back_to_back();
    logic [127:0] pts [3];
    logic [127:0] keys [3];
    logic [127:0] exps [3];
    int           acc [$];
    int           cyc;
    int           na;
    int           no;
    logic         acc_now;
    for (int i = 0; i < 3; i++) begin
      pts[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      keys[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      exps[i] = aes_enc(pts[i], keys[i]);
    end
    cyc = 0; na = 0; no = 0;
    in_data   = pts[0];
    in_key    = keys[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (no < 3 && cyc < 80) begin
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        chk("b2b_ct", out_data, exps[no]);
        no++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        acc.push_back(cyc);
        na++;
        if (na < 3) begin
          in_data = pts[na];
          in_key  = keys[na];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_outputs", 128'(no), 128'(3));
    chk("b2b_accepts", 128'(acc.size()), 128'(3));
    if (acc.size() == 3) begin
      chk("b2b_spacing1", 128'(acc[1] - acc[0]), 128'(12));
      chk("b2b_spacing2", 128'(acc[2] - acc[1]), 128'(12));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] pt, key;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_key    = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, 128'(0));
    chk("reset_rd_round", 128'(rd_round), 128'(0));
    chk("reset_rd_rcon", 128'(rd_rcon), 128'(0));
    chk("reset_rd_final", 128'(rd_final), 128'(0));
    chk("reset_rd_state", rd_state, 128'(0));
    chk("reset_rd_key", rd_key, 128'(0));
    tick();

    // FIPS-197 C.1 with sequencing pins and 5 cycles of backpressure
    run_block(C1_PT, C1_KEY, C1_CT, 5, 1'b0, 1'b1);
    // FIPS-197 B with input noise while busy
    run_block(B_PT, B_KEY, B_CT, 2, 1'b1, 1'b0);

    // Asynchronous reset in round 5 loses the block
    in_data  = C1_PT;
    in_key   = C1_KEY;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_round", 128'(rd_round), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_rd_round", 128'(rd_round), 128'(0));
    chk("midrst_rd_final", 128'(rd_final), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid2", 128'(out_valid), 128'(0));
    run_block(C1_PT, C1_KEY, C1_CT, 1, 1'b0, 1'b0);

    back_to_back();

    for (int i = 0; i < 4; i++) begin
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(pt, key, aes_enc(pt, key), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
